// File: rtl/pipeline_output_merger_if.sv
// pipeline_output_merger_if
//   Bundles the pipeline-side inputs, flush controls, merged ready/valid
//   output channel and status outputs of pipeline_output_merger.
//   master : producer/consumer side (drives pipe_*, flush_*, merged_ready)
//   slave  : merger side (drives merged_*, count_*, overflow)
interface pipeline_output_merger_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 3
);
   logic [DATA_W-1:0] pipe_data_1;
   logic [DATA_W-1:0] pipe_data_2;
   logic [1:0]        pipe_valid;
   logic              flush_1;
   logic              flush_2;
   logic [DATA_W-1:0] merged_data;
   logic              merged_src;
   logic              merged_valid;
   logic              merged_ready;
   logic [CNT_W-1:0]  count_1;
   logic [CNT_W-1:0]  count_2;
   logic [1:0]        overflow;

   modport master (
      output pipe_data_1, pipe_data_2, pipe_valid, flush_1, flush_2, merged_ready,
      input  merged_data, merged_src, merged_valid, count_1, count_2, overflow
   );

   modport slave (
      input  pipe_data_1, pipe_data_2, pipe_valid, flush_1, flush_2, merged_ready,
      output merged_data, merged_src, merged_valid, count_1, count_2, overflow
   );
endinterface

// File: rtl/pipeline_output_merger.sv
// pipeline_output_merger
//   Buffers two non-back-pressurable pipeline result streams in per-channel
//   FIFOs and merges them round-robin onto one registered ready/valid
//   channel, tagging each word with its source (0 = pipe 1, 1 = pipe 2).
//   Ports:
//     clk, reset : single clock, synchronous active-high reset
//     bus        : pipeline_output_merger_if.slave
//                  (pipe_data_1/2, pipe_valid[1:0], flush_1/2, merged_ready in;
//                   merged_data, merged_src, merged_valid, count_1/2,
//                   overflow[1:0] out)

// One channel FIFO. Full/empty come from the occupancy counter, so the
// pointers simply wrap. A write into a full FIFO is still taken when the
// same cycle pops, since a slot frees up at that edge.
module pom_chan #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flush,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [CNT_W-1:0]  count,
   output logic              ovf
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic              full, wr_ok;

   assign full  = (count == CNT_W'(DEPTH));
   // flushed writes vanish silently; they are not overflows
   assign wr_ok = wr_valid && !flush && (!full || pop);
   assign head  = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (pop)   rptr <= rptr + 1'b1;
         count <= count + CNT_W'(wr_ok) - CNT_W'(pop);
         if (wr_valid && !wr_ok) ovf <= 1'b1;
      end
   end
endmodule

module pipeline_output_merger #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input logic clk,
   input logic reset,
   pipeline_output_merger_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [1:0][DATA_W-1:0] wr_data, head;
   logic [1:0][CNT_W-1:0]  cnt;
   logic [1:0]             flush, avail, pop, ovf;
   logic                   load, sel, last_grant;

   assign wr_data[0] = bus.pipe_data_1;
   assign wr_data[1] = bus.pipe_data_2;
   assign flush      = {bus.flush_2, bus.flush_1};

   for (genvar i = 0; i < 2; i++) begin : g_chan
      pom_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan (
         .clk      (clk),
         .reset    (reset),
         .wr_valid (bus.pipe_valid[i]),
         .wr_data  (wr_data[i]),
         .flush    (flush[i]),
         .pop      (pop[i]),
         .head     (head[i]),
         .count    (cnt[i]),
         .ovf      (ovf[i])
      );
   end

   // A channel being flushed this cycle is invisible to the arbiter.
   always_comb begin
      avail = '0;
      for (int i = 0; i < 2; i++) avail[i] = (cnt[i] != '0) && !flush[i];
      load = (!bus.merged_valid || bus.merged_ready) && (avail != 2'b00);
      // tie goes to the channel that did not win last time
      sel  = (&avail) ? ~last_grant : avail[1];
      pop  = '0;
      if (load) pop[sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.merged_data  <= '0;
         bus.merged_src   <= 1'b0;
         bus.merged_valid <= 1'b0;
         last_grant       <= 1'b1;
      end else if (load) begin
         bus.merged_data  <= head[sel];
         bus.merged_src   <= sel;
         bus.merged_valid <= 1'b1;
         last_grant       <= sel;
      end else if (bus.merged_ready) begin
         bus.merged_valid <= 1'b0;
      end
   end

   assign bus.count_1  = cnt[0];
   assign bus.count_2  = cnt[1];
   assign bus.overflow = ovf;
endmodule

// File: tb/tb_pipeline_output_merger.sv
module tb_pipeline_output_merger;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_output_merger_if #(.DATA_W(DW), .CNT_W(3)) bus ();

   pipeline_output_merger #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int vectors = 0;
   int errs    = 0;
   bit started = 1'b0;

   // reference model: two bounded queues, one output slot, last winner
   logic [DW-1:0] mq1[$], mq2[$];
   logic [DW:0]   expq[$];       // {src, data} loaded, awaiting handshake
   logic          m_ov, m_os, m_lg;
   logic [DW-1:0] m_od;
   logic [1:0]    m_ovf;
   logic [DW:0]   mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input logic [1:0] pv, input logic [DW-1:0] d1, d2,
                        input logic f1, f2, rdy, rst);
      logic a1, a2, ld, s;
      logic [DW-1:0] w;
      if (rst) begin
         mq1.delete(); mq2.delete(); expq.delete();
         m_ov = 0; m_os = 0; m_od = '0; m_lg = 1; m_ovf = 2'b00;
         return;
      end
      a1 = (mq1.size() > 0) && !f1;
      a2 = (mq2.size() > 0) && !f2;
      ld = (!m_ov || rdy) && (a1 || a2);
      if (ld) begin
         s = (a1 && a2) ? !m_lg : a2;
         w = s ? mq2.pop_front() : mq1.pop_front();
         expq.push_back({s, w});
         m_ov = 1; m_od = w; m_os = s; m_lg = s;
      end else if (rdy) m_ov = 0;
      if (f1) mq1.delete();
      else if (pv[0]) begin
         if (mq1.size() < DEPTH) mq1.push_back(d1); else m_ovf[0] = 1;
      end
      if (f2) mq2.delete();
      else if (pv[1]) begin
         if (mq2.size() < DEPTH) mq2.push_back(d2); else m_ovf[1] = 1;
      end
   endtask

   task automatic step(input logic [1:0] pv, input logic [DW-1:0] d1, d2,
                       input logic f1, f2, rdy, rst);
      bus.pipe_valid   = pv;
      bus.pipe_data_1  = d1;
      bus.pipe_data_2  = d2;
      bus.flush_1      = f1;
      bus.flush_2      = f2;
      bus.merged_ready = rdy;
      reset            = rst;
      @(posedge clk);
      #1;
      model(pv, d1, d2, f1, f2, rdy, rst);
   endtask

   task automatic do_reset();
      step(2'b00, '0, '0, 0, 0, 0, 1);
      step(2'b00, '0, '0, 0, 0, 0, 1);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(2'b00, '0, '0, 0, 0, 1, 0);
   endtask

   // monitor: status against the model every cycle, words against the scoreboard
   always @(negedge clk) begin
      if (started) begin
         chk("count_1", 64'(bus.count_1), 64'(mq1.size()));
         chk("count_2", 64'(bus.count_2), 64'(mq2.size()));
         chk("overflow", 64'(bus.overflow), 64'(m_ovf));
         chk("merged_valid", 64'(bus.merged_valid), 64'(m_ov));
         if (bus.merged_valid && bus.merged_ready) begin
            if (expq.size() == 0) chk("unexpected_word", 64'(1), 64'(0));
            else begin
               mon_e = expq.pop_front();
               chk("merged_data", 64'(bus.merged_data), 64'(mon_e[DW-1:0]));
               chk("merged_src", 64'(bus.merged_src), 64'(mon_e[DW]));
            end
         end
      end
   end

   initial begin
      do_reset();
      started = 1'b1;
      chk("rst_valid", 64'(bus.merged_valid), 64'(0));
      chk("rst_data", 64'(bus.merged_data), 64'(0));

      // single word latency
      step(2'b01, 32'hA5A5_0001, '0, 0, 0, 1, 0);
      step(2'b00, '0, '0, 0, 0, 1, 0);
      chk("t1_valid", 64'(bus.merged_valid), 64'(1));
      chk("t1_data", 64'(bus.merged_data), 64'h0000_0000_A5A5_0001);
      chk("t1_src", 64'(bus.merged_src), 64'(0));
      chk("t1_count1", 64'(bus.count_1), 64'(0));
      drain(2);

      // both channels streaming: alternation from src 0
      do_reset();
      for (int k = 0; k < 6; k++) step(2'b11, 32'h100 + k, 32'h200 + k, 0, 0, 1, 0);
      drain(14);
      chk("t2_overflow", 64'(bus.overflow), 64'(0));

      // overflow with ready low
      do_reset();
      for (int k = 0; k < 6; k++) step(2'b01, 32'h300 + k, '0, 0, 0, 0, 0);
      chk("t3_count1", 64'(bus.count_1), 64'(4));
      chk("t3_overflow", 64'(bus.overflow), 64'(1));
      chk("t3_hold", 64'(bus.merged_data), 64'h300);
      drain(8);

      // flush_2 with a same-cycle write, output word pending
      do_reset();
      for (int k = 0; k < 4; k++) step(2'b10, '0, 32'h400 + k, 0, 0, 0, 0);
      step(2'b10, '0, 32'h4FF, 0, 1, 0, 0);
      chk("t4_count2", 64'(bus.count_2), 64'(0));
      chk("t4_overflow", 64'(bus.overflow), 64'(0));
      chk("t4_pending", 64'(bus.merged_data), 64'h400);
      drain(4);

      // write into a full channel on the cycle it pops
      do_reset();
      for (int k = 0; k < 5; k++) step(2'b01, 32'h500 + k, '0, 0, 0, 0, 0);
      chk("t5_full", 64'(bus.count_1), 64'(4));
      step(2'b01, 32'h505, '0, 0, 0, 1, 0);
      chk("t5_count1", 64'(bus.count_1), 64'(4));
      chk("t5_overflow", 64'(bus.overflow), 64'(0));
      chk("t5_data", 64'(bus.merged_data), 64'h501);
      drain(8);

      // reset mid-transfer, then tie goes to channel 1
      do_reset();
      for (int k = 0; k < 3; k++) step(2'b11, 32'h600 + k, 32'h700 + k, 0, 0, 0, 0);
      step(2'b00, '0, '0, 0, 0, 0, 1);
      chk("t6_valid", 64'(bus.merged_valid), 64'(0));
      chk("t6_data", 64'(bus.merged_data), 64'(0));
      chk("t6_counts", 64'({bus.count_1, bus.count_2}), 64'(0));
      chk("t6_overflow", 64'(bus.overflow), 64'(0));
      step(2'b11, 32'h610, 32'h710, 0, 0, 1, 0);
      step(2'b00, '0, '0, 0, 0, 1, 0);
      chk("t6_tie_src", 64'(bus.merged_src), 64'(0));
      chk("t6_tie_data", 64'(bus.merged_data), 64'h610);
      drain(4);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         step(2'($urandom_range(0, 3)), $urandom, $urandom,
              ($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 249) == 0));
      end
      drain(12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
